rect_ctl: RTL and testbench



---
 rtl/rect_ctl.sv | 119 +++++++++++
 tb/tb_rect_ctl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/rect_ctl.sv
// Bouncing-rectangle position controller: moves a rectangle once per frame
// during vertical blanking and reflects it off the active-area borders.
module rect_ctl #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned V_ACTIVE = 600,
  parameter int unsigned RECT_W   = 48,
  parameter int unsigned RECT_H   = 64,
  parameter int unsigned X_INIT   = 0,
  parameter int unsigned Y_INIT   = 0
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [3:0]  step,
  input  logic        vblnk,
  output logic [10:0] xpos,
  output logic [10:0] ypos,
  output logic        pos_valid,
  output logic [15:0] frame_cnt
);

  localparam int unsigned POS_W = 11;
  localparam int unsigned CNT_W = 16;
  localparam logic [POS_W-1:0] X_MAX = POS_W'(H_ACTIVE - RECT_W);
  localparam logic [POS_W-1:0] Y_MAX = POS_W'(V_ACTIVE - RECT_H);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VB = 2'd1,
    CALC    = 2'd2,
    COMMIT  = 2'd3
  } state_t;

  state_t           state, state_nx;
  logic             vblnk_d;
  logic             frame_edge_c;
  logic             dir_x, dir_y;      // 0 = right/down, 1 = left/up
  logic [POS_W-1:0] x_nx_q, y_nx_q;
  logic             dx_nx_q, dy_nx_q;
  logic [POS_W:0]   x_move_c, y_move_c;

  // One axis step in 12-bit arithmetic; returns {new_dir, new_pos}.
  function automatic logic [POS_W:0] move_axis(input logic [POS_W-1:0] pos,
                                               input logic             dir,
                                               input logic [3:0]       s,
                                               input logic [POS_W-1:0] lim);
    logic [POS_W:0] pos12, s12, res;
    pos12 = {1'b0, pos};
    s12   = (POS_W+1)'(s);
    res   = {dir, pos};
    if (!dir) begin
      if (pos12 + s12 >= {1'b0, lim}) res = {1'b1, lim};
      else                            res = {1'b0, POS_W'(pos12 + s12)};
    end else begin
      if (pos12 <= s12) res = {1'b0, POS_W'(0)};
      else              res = {1'b1, POS_W'(pos12 - s12)};
    end
    return res;
  endfunction

  assign frame_edge_c = vblnk & ~vblnk_d;
  assign x_move_c     = move_axis(xpos, dir_x, step, X_MAX);
  assign y_move_c     = move_axis(ypos, dir_y, step, Y_MAX);

  // Next-state logic; frame edges outside WAIT_VB are dropped.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (enable) state_nx = WAIT_VB;
      WAIT_VB: begin
        if (frame_edge_c) state_nx = CALC;
        else if (!enable) state_nx = IDLE;
      end
      CALC:    state_nx = COMMIT;
      COMMIT:  state_nx = enable ? WAIT_VB : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Datapath: capture the move in CALC, publish it in COMMIT.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vblnk_d   <= 1'b0;
      xpos      <= POS_W'(X_INIT);
      ypos      <= POS_W'(Y_INIT);
      dir_x     <= 1'b0;
      dir_y     <= 1'b0;
      x_nx_q    <= POS_W'(X_INIT);
      y_nx_q    <= POS_W'(Y_INIT);
      dx_nx_q   <= 1'b0;
      dy_nx_q   <= 1'b0;
      pos_valid <= 1'b0;
      frame_cnt <= '0;
    end else begin
      vblnk_d   <= vblnk;
      pos_valid <= 1'b0;
      if (state == CALC) begin
        x_nx_q  <= x_move_c[POS_W-1:0];
        dx_nx_q <= x_move_c[POS_W];
        y_nx_q  <= y_move_c[POS_W-1:0];
        dy_nx_q <= y_move_c[POS_W];
      end
      if (state == COMMIT) begin
        xpos      <= x_nx_q;
        ypos      <= y_nx_q;
        dir_x     <= dx_nx_q;
        dir_y     <= dy_nx_q;
        pos_valid <= 1'b1;
        frame_cnt <= frame_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rect_ctl.sv
// Scoreboard bench for rect_ctl: driver queues expected updates, a negedge
// monitor pops one per pos_valid pulse and compares position, count, latency.
module tb_rect_ctl;

  logic        pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [3:0]  step = 4'd0;
  logic        vblnk = 1'b0;
  logic [10:0] xpos, ypos;
  logic        pos_valid;
  logic [15:0] frame_cnt;

  // X_MAX = 800-48 = 752, Y_MAX = 80-64 = 16
  rect_ctl #(
    .H_ACTIVE(800), .V_ACTIVE(80), .RECT_W(48), .RECT_H(64),
    .X_INIT(750), .Y_INIT(3)
  ) dut (
    .pclk(pclk), .rst_n(rst_n), .enable(enable), .step(step), .vblnk(vblnk),
    .xpos(xpos), .ypos(ypos), .pos_valid(pos_valid), .frame_cnt(frame_cnt)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  typedef struct {
    int x;
    int y;
    int fc;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int passed = 0;

  int mx, my, mdx, mdy, mfc;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic void model_axis(inout int p, inout int d, input int s, input int lim);
    if (d == 0) begin
      if (p + s >= lim) begin p = lim; d = 1; end
      else p = p + s;
    end else begin
      if (p <= s) begin p = 0; d = 0; end
      else p = p - s;
    end
  endfunction

  task automatic model_reset();
    mx = 750; my = 3; mdx = 0; mdy = 0; mfc = 0;
  endtask

  // Called at a negedge with vblnk about to rise while the DUT waits for VB.
  task automatic push_expected();
    exp_t e;
    model_axis(mx, mdx, int'(step), 752);
    model_axis(my, mdy, int'(step), 16);
    mfc = (mfc + 1) & 16'hFFFF;
    e.x = mx; e.y = my; e.fc = mfc; e.cyc = cyc + 3;
    sb.push_back(e);
  endtask

  task automatic frame();
    @(negedge pclk);
    vblnk = 1'b1;
    push_expected();
    @(negedge pclk);
    vblnk = 1'b0;
    repeat (4) @(negedge pclk);
  endtask

  // Monitor: every pos_valid pulse must match the oldest queued expectation.
  always @(negedge pclk) begin
    if (rst_n && pos_valid) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_pos_valid: got pulse at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_xpos", int'(xpos), e.x);
        check("sb_ypos", int'(ypos), e.y);
        check("sb_frame_cnt", int'(frame_cnt), e.fc);
        check("sb_latency_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    model_reset();
    step = 4'd5;
    repeat (2) @(negedge pclk);
    check("rst_xpos", int'(xpos), 750);
    check("rst_ypos", int'(ypos), 3);
    check("rst_pos_valid", int'(pos_valid), 0);
    check("rst_frame_cnt", int'(frame_cnt), 0);

    rst_n = 1'b1;
    enable = 1'b1;
    repeat (2) @(negedge pclk);

    // Bounce off right edge and off top edge, step 5
    for (int i = 1; i <= 8; i++) begin
      frame();
      if (i == 1) check("right_bounce_x", int'(xpos), 752);
      if (i == 2) check("after_bounce_x", int'(xpos), 747);
      if (i == 3) check("bottom_bounce_y", int'(ypos), 16);
      if (i == 7) check("top_bounce_y", int'(ypos), 0);
      if (i == 8) check("after_top_y", int'(ypos), 5);
    end

    // step = 0: pulses and counts, position held
    step = 4'd0;
    repeat (3) frame();
    check("step0_x", int'(xpos), 717);
    check("step0_y", int'(ypos), 5);
    check("step0_cnt", int'(frame_cnt), 11);

    step = 4'd3;
    frame();

    // vblnk glitch: second rise lands in COMMIT and must be ignored
    @(negedge pclk);
    vblnk = 1'b1;
    push_expected();
    @(negedge pclk); vblnk = 1'b0;
    @(negedge pclk); vblnk = 1'b1;
    @(negedge pclk);
    @(negedge pclk); vblnk = 1'b0;
    repeat (4) @(negedge pclk);
    check("glitch_cnt", int'(frame_cnt), 13);

    // enable dropped during CALC: update completes, then idle
    @(negedge pclk);
    vblnk = 1'b1;
    push_expected();
    @(negedge pclk);
    vblnk = 1'b0;
    enable = 1'b0;
    repeat (4) @(negedge pclk);
    for (int i = 0; i < 10; i++) begin
      @(negedge pclk); vblnk = 1'b1;
      @(negedge pclk); vblnk = 1'b0;
    end
    repeat (2) @(negedge pclk);
    check("disabled_x", int'(xpos), 708);
    check("disabled_y", int'(ypos), 14);
    check("disabled_cnt", int'(frame_cnt), 14);

    enable = 1'b1;
    repeat (2) @(negedge pclk);
    frame();
    check("reenable_y_clamp", int'(ypos), 16);

    // Reset during COMMIT aborts the update
    @(negedge pclk); vblnk = 1'b1;
    @(negedge pclk); vblnk = 1'b0;
    @(negedge pclk); rst_n = 1'b0;
    #1;
    check("midrst_xpos", int'(xpos), 750);
    check("midrst_ypos", int'(ypos), 3);
    check("midrst_pos_valid", int'(pos_valid), 0);
    check("midrst_frame_cnt", int'(frame_cnt), 0);
    sb.delete();
    model_reset();
    repeat (2) @(negedge pclk);
    check("midrst_hold_pos_valid", int'(pos_valid), 0);

    // vblnk already high at release must not produce an update
    rst_n = 1'b1;
    vblnk = 1'b1;
    repeat (2) @(negedge pclk);
    vblnk = 1'b0;
    repeat (2) @(negedge pclk);
    step = 4'd4;
    frame();
    check("post_rst_x", int'(xpos), 752);
    check("post_rst_y", int'(ypos), 7);
    check("post_rst_cnt", int'(frame_cnt), 1);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge pclk);
    check("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
